// File: rtl/fp_simd_pkg.sv
// Shared definitions for the FP SIMD issue slice: lane geometry, opcodes and FSM states.
// Used by fp_simd_issue and fp_issue_fifo; see fp_simd_issue.sv for FP_SIMD_ISSUE_TAG_EN.
package fp_simd_pkg;

    localparam int unsigned SIMD_WIDTH = 4;
    localparam int unsigned FP_W       = 22;
    localparam int unsigned VEC_W      = SIMD_WIDTH * FP_W;
    localparam int unsigned OP_W       = 3;

    typedef logic [OP_W-1:0]  opcode_t;
    typedef logic [VEC_W-1:0] vec_t;

    localparam opcode_t OP_ADD        = 3'b000;
    localparam opcode_t OP_SUB        = 3'b001;
    localparam opcode_t OP_MUL        = 3'b010;
    localparam opcode_t OP_RCP        = 3'b011;
    localparam opcode_t OP_REDUCE_ADD = 3'b100;
    localparam opcode_t OP_REDUCE_MUL = 3'b101;
    localparam opcode_t OP_LOAD1      = 3'b110;
    localparam opcode_t OP_LOAD2      = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StRsp
    } issue_state_e;

    // Loads only write unit-internal registers and never return a result.
    function automatic logic op_is_load(input opcode_t op);
        return (op == OP_LOAD1) || (op == OP_LOAD2);
    endfunction

endpackage

// File: rtl/fp_issue_fifo.sv
// Command FIFO for the FP SIMD issue slice: power-of-two depth, synchronous flush,
// occupancy output. Push is refused when full; pop is ignored when empty.
module fp_issue_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [LVL_W-1:0] level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Flush wins over both push and pop so nothing survives into the next cycle.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fp_simd_issue.sv
// Queues FP SIMD commands and issues them one at a time to the SIMD unit, returning results
// over a valid/ready handshake. Define FP_SIMD_ISSUE_TAG_EN to carry caller tags to o_rsp_tag.
module fp_simd_issue
    import fp_simd_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [2:0]       i_cmd_opcode,
    input  logic [87:0]      i_cmd_in1,
    input  logic [87:0]      i_cmd_in2,
    input  logic [TAG_W-1:0] i_cmd_tag,
    input  logic             i_flush,
    output logic             o_simd_en,
    output logic [2:0]       o_simd_opcode,
    output logic [87:0]      o_simd_in1,
    output logic [87:0]      o_simd_in2,
    input  logic             i_simd_busy,
    input  logic             i_simd_valid,
    input  logic [87:0]      i_simd_out,
    output logic             o_rsp_valid,
    output logic [87:0]      o_rsp_data,
    output logic [TAG_W-1:0] o_rsp_tag,
    input  logic             i_rsp_ready,
    output logic [LVL_W-1:0] o_level
);

`ifdef FP_SIMD_ISSUE_TAG_EN
    localparam int unsigned CMD_W = OP_W + 2 * VEC_W + TAG_W;
`else
    localparam int unsigned CMD_W = OP_W + 2 * VEC_W;
`endif

    logic [CMD_W-1:0] cmd_wdata, cmd_rdata;
    logic             fifo_empty, fifo_full;
    logic             issue_go;
    opcode_t          head_op;
    vec_t             head_in1, head_in2;

    issue_state_e     state_q;
    logic             simd_en_q;
    opcode_t          op_q;
    vec_t             in1_q, in2_q;
    logic             rsp_valid_q;
    vec_t             rsp_data_q;

`ifdef FP_SIMD_ISSUE_TAG_EN
    assign cmd_wdata = {i_cmd_opcode, i_cmd_in1, i_cmd_in2, i_cmd_tag};
`else
    assign cmd_wdata = {i_cmd_opcode, i_cmd_in1, i_cmd_in2};
`endif

    assign head_op  = cmd_rdata[CMD_W-1 -: OP_W];
    assign head_in1 = cmd_rdata[CMD_W-OP_W-1 -: VEC_W];
    assign head_in2 = cmd_rdata[CMD_W-OP_W-VEC_W-1 -: VEC_W];

    // A flush in the same cycle must not let a queued entry escape into the issue register.
    assign issue_go = (state_q == StIdle) && !fifo_empty && !i_simd_busy && !i_flush;

    fp_issue_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (i_cmd_valid),
        .data_i  (cmd_wdata),
        .pop_i   (issue_go),
        .flush_i (i_flush),
        .data_o  (cmd_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (o_level)
    );

    assign o_cmd_ready = !fifo_full;

    // Issue register is loaded on pop and left untouched until the next pop, so the unit
    // sees a stable opcode/operands for the whole operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            simd_en_q   <= 1'b0;
            op_q        <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (issue_go) begin
                        state_q   <= StIssue;
                        simd_en_q <= 1'b1;
                        op_q      <= head_op;
                        in1_q     <= head_in1;
                        in2_q     <= head_in2;
                    end
                end
                StIssue: begin
                    simd_en_q <= 1'b0;
                    state_q   <= op_is_load(op_q) ? StIdle : StWait;
                end
                StWait: begin
                    if (i_simd_valid) begin
                        state_q     <= StRsp;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= i_simd_out;
                    end
                end
                StRsp: begin
                    if (i_rsp_ready) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef FP_SIMD_ISSUE_TAG_EN
    logic [TAG_W-1:0] tag_q, rsp_tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q     <= '0;
            rsp_tag_q <= '0;
        end else begin
            if (issue_go) begin
                tag_q <= cmd_rdata[TAG_W-1:0];
            end
            if ((state_q == StWait) && i_simd_valid) begin
                rsp_tag_q <= tag_q;
            end
        end
    end

    assign o_rsp_tag = rsp_tag_q;
`else
    logic unused_tag;
    assign unused_tag = ^i_cmd_tag;
    assign o_rsp_tag  = '0;
`endif

    assign o_simd_en     = simd_en_q;
    assign o_simd_opcode = op_q;
    assign o_simd_in1    = in1_q;
    assign o_simd_in2    = in2_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_fp_simd_issue.sv
// Directed bench for fp_simd_issue with a behavioural FP SIMD unit and a response scoreboard.
module tb_fp_simd_issue;
    import fp_simd_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             i_cmd_valid;
    logic             o_cmd_ready;
    logic [2:0]       i_cmd_opcode;
    logic [87:0]      i_cmd_in1;
    logic [87:0]      i_cmd_in2;
    logic [TAG_W-1:0] i_cmd_tag;
    logic             i_flush;
    logic             o_simd_en;
    logic [2:0]       o_simd_opcode;
    logic [87:0]      o_simd_in1;
    logic [87:0]      o_simd_in2;
    logic             i_simd_busy;
    logic             i_simd_valid;
    logic [87:0]      i_simd_out;
    logic             o_rsp_valid;
    logic [87:0]      o_rsp_data;
    logic [TAG_W-1:0] o_rsp_tag;
    logic             i_rsp_ready;
    logic [LVL_W-1:0] o_level;

    fp_simd_issue #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_opcode  (i_cmd_opcode),
        .i_cmd_in1     (i_cmd_in1),
        .i_cmd_in2     (i_cmd_in2),
        .i_cmd_tag     (i_cmd_tag),
        .i_flush       (i_flush),
        .o_simd_en     (o_simd_en),
        .o_simd_opcode (o_simd_opcode),
        .o_simd_in1    (o_simd_in1),
        .o_simd_in2    (o_simd_in2),
        .i_simd_busy   (i_simd_busy),
        .i_simd_valid  (i_simd_valid),
        .i_simd_out    (i_simd_out),
        .o_rsp_valid   (o_rsp_valid),
        .o_rsp_data    (o_rsp_data),
        .o_rsp_tag     (o_rsp_tag),
        .i_rsp_ready   (i_rsp_ready),
        .o_level       (o_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [87:0]      data;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    rsp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   rsp_cnt  = 0;
    int   en_cnt   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [TAG_W-1:0] exp_tag(input logic [TAG_W-1:0] t);
`ifdef FP_SIMD_ISSUE_TAG_EN
        return t;
`else
        return t & '0;
`endif
    endfunction

    function automatic logic [87:0] rep(input logic [21:0] lane);
        return {4{lane}};
    endfunction

    // Behavioural SIMD unit: integer lane arithmetic, lane 0 in the top bits.
    function automatic logic [87:0] model_calc(input logic [2:0] op, input logic [87:0] a,
                                               input logic [87:0] b);
        logic [87:0] r;
        logic [21:0] acc;
        r = '0;
        case (op)
            OP_ADD: for (int i = 0; i < 4; i++) r[87-22*i -: 22] = a[87-22*i -: 22] + b[87-22*i -: 22];
            OP_SUB: for (int i = 0; i < 4; i++) r[87-22*i -: 22] = a[87-22*i -: 22] - b[87-22*i -: 22];
            OP_MUL: for (int i = 0; i < 4; i++) r[87-22*i -: 22] = a[87-22*i -: 22] * b[87-22*i -: 22];
            OP_RCP: for (int i = 0; i < 4; i++) r[87-22*i -: 22] = ~a[87-22*i -: 22];
            OP_REDUCE_ADD: begin
                acc = '0;
                for (int i = 0; i < 4; i++) acc = acc + a[87-22*i -: 22];
                r[87:66] = acc;
            end
            OP_REDUCE_MUL: begin
                acc = 22'd1;
                for (int i = 0; i < 4; i++) acc = acc * a[87-22*i -: 22];
                r[87:66] = acc;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    logic        m_busy, m_valid, hold_busy;
    logic [87:0] m_out, m_a, m_b;
    logic [2:0]  m_op;
    int          m_cnt;

    assign i_simd_busy  = m_busy | hold_busy;
    assign i_simd_valid = m_valid;
    assign i_simd_out   = m_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_out   <= '0;
            m_a     <= '0;
            m_b     <= '0;
            m_op    <= '0;
            m_cnt   <= 0;
        end else begin
            m_valid <= 1'b0;
            if (o_simd_en) begin
                m_cnt  <= ((o_simd_opcode == OP_REDUCE_ADD) || (o_simd_opcode == OP_REDUCE_MUL)) ? 5 : 3;
                m_busy <= 1'b1;
                m_op   <= o_simd_opcode;
                m_a    <= o_simd_in1;
                m_b    <= o_simd_in2;
            end else if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end else if (m_cnt == 1) begin
                m_cnt   <= 0;
                m_valid <= 1'b1;
                m_out   <= model_calc(m_op, m_a, m_b);
                m_busy  <= 1'b0;
            end
        end
    end

    // Monitor: scoreboard compare on every response handshake, plus issue-side observations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_simd_en) en_cnt++;
            if (m_valid && !op_is_load(m_op)) begin
                check("simd_op_hold", {o_simd_opcode, o_simd_in1}, {m_op, m_a});
            end
            if (o_rsp_valid && i_rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp", o_rsp_valid, 1'b0);
                end else begin
                    rsp_t e;
                    e = sb_q.pop_front();
                    check("rsp_data", o_rsp_data, e.data);
                    check("rsp_tag", o_rsp_tag, e.tag);
                end
                rsp_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [87:0] a, input logic [87:0] b,
                            input logic [TAG_W-1:0] tag);
        int budget = 200;
        while (!o_cmd_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (!o_cmd_ready) check("push_ready_timeout", o_cmd_ready, 1'b1);
        i_cmd_valid  = 1'b1;
        i_cmd_opcode = op;
        i_cmd_in1    = a;
        i_cmd_in2    = b;
        i_cmd_tag    = tag;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input int target, input int budget);
        while (rsp_cnt < target && budget > 0) begin
            tick();
            budget--;
        end
        check(name, rsp_cnt, target);
    endtask

    task automatic check_reset(input string p);
        check({p, "_level"}, o_level, '0);
        check({p, "_cmd_ready"}, o_cmd_ready, 1'b1);
        check({p, "_simd_en"}, o_simd_en, 1'b0);
        check({p, "_rsp_valid"}, o_rsp_valid, 1'b0);
        check({p, "_simd_opcode"}, o_simd_opcode, '0);
        check({p, "_simd_in1"}, o_simd_in1, '0);
        check({p, "_simd_in2"}, o_simd_in2, '0);
        check({p, "_rsp_data"}, o_rsp_data, '0);
        check({p, "_rsp_tag"}, o_rsp_tag, '0);
    endtask

    logic [2:0]  t2_op  [5];
    logic [87:0] t2_a   [5];
    logic [87:0] t2_b   [5];
    logic [87:0] t2_exp [5];

    initial begin
        int base, e0;
        rst_n        = 1'b0;
        i_cmd_valid  = 1'b0;
        i_cmd_opcode = '0;
        i_cmd_in1    = '0;
        i_cmd_in2    = '0;
        i_cmd_tag    = '0;
        i_flush      = 1'b0;
        i_rsp_ready  = 1'b1;
        hold_busy    = 1'b0;
        repeat (3) tick();
        check_reset("rst");
        rst_n = 1'b1;
        tick();

        // Single add.
        e0 = en_cnt;
        sb_q.push_back('{data: rep(22'h1E0000), tag: exp_tag(4'd3)});
        push_cmd(OP_ADD, rep(22'h0F0000), rep(22'h0F0000), 4'd3);
        wait_rsp("t1_rsp_count", 1, 50);
        repeat (5) tick();
        check("t1_en_pulses", en_cnt - e0, 1);

        // Fill past DEPTH while the unit reports busy.
        t2_op[0] = OP_SUB; t2_a[0] = rep(22'h000005); t2_b[0] = rep(22'h000003);
        t2_exp[0] = rep(22'h000002);
        t2_op[1] = OP_MUL; t2_a[1] = rep(22'h000003); t2_b[1] = rep(22'h000004);
        t2_exp[1] = rep(22'h00000C);
        t2_op[2] = OP_ADD;
        t2_a[2] = {22'h100000, 22'h000001, 22'h000002, 22'h000003};
        t2_b[2] = {22'h0FFFFF, 22'h000010, 22'h000020, 22'h000030};
        t2_exp[2] = {22'h1FFFFF, 22'h000011, 22'h000022, 22'h000033};
        t2_op[3] = OP_SUB; t2_a[3] = rep(22'h000000); t2_b[3] = rep(22'h000001);
        t2_exp[3] = rep(22'h3FFFFF);
        t2_op[4] = OP_ADD; t2_a[4] = rep(22'h000009); t2_b[4] = rep(22'h000009);
        t2_exp[4] = rep(22'h000012);
        base = rsp_cnt;
        hold_busy = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            i_cmd_valid  = 1'b1;
            i_cmd_opcode = t2_op[i];
            i_cmd_in1    = t2_a[i];
            i_cmd_in2    = t2_b[i];
            i_cmd_tag    = 4'(8 + i);
            check("t2_ready", o_cmd_ready, (i < 4) ? 1'b1 : 1'b0);
            tick();
        end
        i_cmd_valid = 1'b0;
        check("t2_level_full", o_level, 3'd4);
        check("t2_ready_full", o_cmd_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back('{data: t2_exp[i], tag: exp_tag(4'(8 + i))});
        end
        hold_busy = 1'b0;
        wait_rsp("t2_rsp_count", base + 4, 200);
        check("t2_level_drained", o_level, '0);

        // load1 then reduce_add: only the reduce responds.
        base = rsp_cnt;
        e0   = en_cnt;
        sb_q.push_back('{data: {22'h00000A, 66'h0}, tag: exp_tag(4'd4)});
        push_cmd(OP_LOAD1, rep(22'h00ABCD), rep(22'h000001), 4'd2);
        push_cmd(OP_REDUCE_ADD, {22'd1, 22'd2, 22'd3, 22'd4}, '0, 4'd4);
        wait_rsp("t3_rsp_count", base + 1, 80);
        repeat (15) tick();
        check("t3_rsp_exactly_one", rsp_cnt, base + 1);
        check("t3_en_pulses", en_cnt - e0, 2);

        // Response back-pressure.
        base = rsp_cnt;
        i_rsp_ready = 1'b0;
        sb_q.push_back('{data: rep(22'h000003), tag: exp_tag(4'd5)});
        sb_q.push_back('{data: rep(22'h00000F), tag: exp_tag(4'd6)});
        push_cmd(OP_ADD, rep(22'h000001), rep(22'h000002), 4'd5);
        push_cmd(OP_SUB, rep(22'h000010), rep(22'h000001), 4'd6);
        begin
            int budget = 50;
            while (!o_rsp_valid && budget > 0) begin
                tick();
                budget--;
            end
        end
        check("t4_rsp_valid", o_rsp_valid, 1'b1);
        e0 = en_cnt;
        for (int i = 0; i < 20; i++) begin
            check("t4_rsp_stable", {o_rsp_valid, o_rsp_data, o_rsp_tag},
                  {1'b1, rep(22'h000003), exp_tag(4'd5)});
            tick();
        end
        check("t4_no_issue", en_cnt - e0, 0);
        check("t4_level", o_level, 3'd1);
        i_rsp_ready = 1'b1;
        wait_rsp("t4_rsp_count", base + 2, 80);

        // Flush with three queued and one in flight.
        base = rsp_cnt;
        e0   = en_cnt;
        sb_q.push_back('{data: rep(22'h00000F), tag: exp_tag(4'd1)});
        push_cmd(OP_ADD, rep(22'h000007), rep(22'h000008), 4'd1);
        push_cmd(OP_MUL, rep(22'h000002), rep(22'h000002), 4'd2);
        push_cmd(OP_SUB, rep(22'h000009), rep(22'h000001), 4'd3);
        push_cmd(OP_RCP, rep(22'h000000), rep(22'h000000), 4'd4);
        check("t5_level_pre", o_level, 3'd3);
        i_flush      = 1'b1;
        i_cmd_valid  = 1'b1;
        i_cmd_opcode = OP_ADD;
        i_cmd_in1    = rep(22'h000011);
        i_cmd_in2    = rep(22'h000011);
        i_cmd_tag    = 4'd9;
        tick();
        i_flush     = 1'b0;
        i_cmd_valid = 1'b0;
        check("t5_level_flushed", o_level, '0);
        wait_rsp("t5_rsp_count", base + 1, 60);
        repeat (20) tick();
        check("t5_rsp_exactly_one", rsp_cnt, base + 1);
        check("t5_en_pulses", en_cnt - e0, 1);

        // Reset while waiting on the unit.
        base = rsp_cnt;
        e0   = en_cnt;
        push_cmd(OP_ADD, rep(22'h000055), rep(22'h000011), 4'd7);
        repeat (3) tick();
        rst_n = 1'b0;
        #2;
        check_reset("t6_rst");
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("t6_no_rsp", rsp_cnt, base);
        check("t6_en_pulses", en_cnt - e0, 1);
        check("t6_rsp_valid_low", o_rsp_valid, 1'b0);

        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fp_simd_issue.md
FP_SIMD_ISSUE -- requirements
Module: fp_simd_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TAG_W, default 4, command tag width.
REQ-003 SHALL have clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have i_cmd_valid  input  1  command offered.
REQ-006 SHALL have o_cmd_ready  output  1  FIFO not full.
REQ-007 SHALL have i_cmd_opcode  input  3  FP SIMD opcode (000 add, 001 sub, 010 mul, 011 rcp, 100 reduce_add, 101 reduce_mul, 110 load1, 111 load2).
REQ-008 SHALL have i_cmd_in1 and i_cmd_in2  input  88  four 22-bit lanes each, lane 0 in bits 87:66.
REQ-009 SHALL have i_cmd_tag  input  TAG_W  caller tag.
REQ-010 SHALL have i_flush  input  1  discard queued, unissued commands.
REQ-011 SHALL have o_simd_en, o_simd_opcode(3), o_simd_in1(88), o_simd_in2(88)  outputs  drive FP SIMD unit.
REQ-012 SHALL have i_simd_busy, i_simd_valid (1 each), i_simd_out (88)  inputs  from FP SIMD unit.
REQ-013 SHALL have o_rsp_valid(1), o_rsp_data(88), o_rsp_tag(TAG_W) outputs and i_rsp_ready(1) input, result handshake.
REQ-014 SHALL have o_level  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-015 Command accepted on a cycle with i_cmd_valid && o_cmd_ready; o_cmd_ready = (o_level < DEPTH).
REQ-016 Issue FSM states: IDLE, ISSUE, WAIT, RSP.
REQ-017 IDLE -> ISSUE when FIFO non-empty and i_simd_busy==0; head entry latched into the issue register, popped.
REQ-018 ISSUE: o_simd_en=1 for exactly one cycle; load opcodes (11x) -> IDLE (no response); all others -> WAIT.
REQ-019 o_simd_opcode/in1/in2 SHALL hold the issue register from ISSUE until leaving WAIT (the unit samples opcode throughout the operation).
REQ-020 WAIT -> RSP on i_simd_valid; i_simd_out and latched tag captured into response register.
REQ-021 RSP: o_rsp_valid=1, data/tag stable until i_rsp_ready; on handshake -> IDLE.
REQ-022 Back-to-back: the next issue occurs no earlier than the cycle after RSP handshake; throughput one non-load op per SIMD latency + 2 cycles min.
REQ-023 Simultaneous push and pop when full: push refused (ready low); when empty: push wins, pop not attempted that cycle.
REQ-024 FIFO pointers wrap modulo DEPTH; o_level never exceeds DEPTH.
REQ-025 i_flush: FIFO emptied next cycle, concurrent push dropped; in-flight (ISSUE/WAIT/RSP) operation completes and responds.
REQ-026 i_simd_valid outside WAIT SHALL be ignored.

Reset
REQ-027 Reset: FSM IDLE, FIFO empty, o_level=0, o_cmd_ready=1, o_simd_en=0, o_rsp_valid=0, o_simd_opcode/in1/in2=0, o_rsp_data=0, o_rsp_tag=0.
REQ-028 Reset asserted mid-operation aborts it immediately; no response produced after release.

Configuration
REQ-029 Macro FP_SIMD_ISSUE_TAG_EN defined: tag stored per FIFO entry and returned on o_rsp_tag.
REQ-030 Macro undefined: no tag storage; i_cmd_tag ignored, o_rsp_tag tied 0; ports unchanged.

Structure
REQ-031 Shared package fp_simd_pkg SHALL hold SIMD_WIDTH=4, FP_W=22, lane-vector width and the eight opcode constants.
REQ-032 FIFO SHALL be sub-module fp_issue_fifo (parameterised width/depth, push/pop/flush/level).

Verification (bench uses FP SIMD behavioural model, valid 4 cycles after en for non-reduce ops)
REQ-033 Single add, in1 lanes 0x0F0000, in2 0x0F0000, tag 3 -> one o_simd_en pulse, o_rsp_valid with model sum, tag 3.
REQ-034 Push 5 commands, DEPTH=4, no pops possible (busy held) -> o_cmd_ready low after 4, o_level=4, 5th not accepted.
REQ-035 load1 then reduce_add -> load gives no response; exactly one response with model reduce result.
REQ-036 i_rsp_ready held low 20 cycles in RSP -> data/tag stable, no further o_simd_en.
REQ-037 3 queued + 1 in WAIT, i_flush -> o_level=0 next cycle, exactly one response (in-flight).
REQ-038 rst_n low during WAIT -> all outputs at reset values; no o_rsp_valid after release.
